// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional skid entry,
// synchronous flush, exception merging and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int EXC_W  = 5,
    parameter int ADDR_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              up_ex,
    input  logic [EXC_W-1:0]  up_excode,
    input  logic [ADDR_W-1:0] up_badvaddr,
    input  logic              loc_ex,
    input  logic [EXC_W-1:0]  loc_excode,
    input  logic [ADDR_W-1:0] loc_badvaddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ex,
    output logic [EXC_W-1:0]  out_excode,
    output logic [ADDR_W-1:0] out_badvaddr,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int ENT_W = DATA_W + 1 + EXC_W + ADDR_W;

    logic [ENT_W-1:0] in_ent;
    logic             accept;
    logic             drain;
    logic             m_valid_q, m_valid_d;
    logic [ENT_W-1:0] m_ent_q, m_ent_d;
    logic [CNT_W-1:0] stall_q;

    // The carried (older) exception always wins over one raised in this stage.
    assign in_ent = {in_data,
                     up_ex | loc_ex,
                     up_ex ? up_excode   : loc_excode,
                     up_ex ? up_badvaddr : loc_badvaddr};

    assign accept = in_valid & in_ready;
    assign drain  = m_valid_q & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic             s_valid_q, s_valid_d;
            logic [ENT_W-1:0] s_ent_q, s_ent_d;
            logic             in_ready_q;

            always_comb begin
                m_valid_d = m_valid_q;
                m_ent_d   = m_ent_q;
                s_valid_d = s_valid_q;
                s_ent_d   = s_ent_q;
                if (flush) begin
                    m_valid_d = 1'b0;
                    m_ent_d   = '0;
                    s_valid_d = 1'b0;
                    s_ent_d   = '0;
                end else if (s_valid_q) begin
                    if (drain) begin
                        m_valid_d = 1'b1;
                        m_ent_d   = s_ent_q;
                        s_valid_d = accept;
                        s_ent_d   = accept ? in_ent : '0;
                    end
                end else if (accept && (!m_valid_q || drain)) begin
                    m_valid_d = 1'b1;
                    m_ent_d   = in_ent;
                end else if (accept) begin
                    s_valid_d = 1'b1;
                    s_ent_d   = in_ent;
                end else if (drain) begin
                    m_valid_d = 1'b0;
                    m_ent_d   = '0;
                end
            end

            // in_ready is a flop so the upstream never sees a path through out_ready.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    s_valid_q  <= 1'b0;
                    s_ent_q    <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    s_valid_q  <= s_valid_d;
                    s_ent_q    <= s_ent_d;
                    in_ready_q <= ~s_valid_d;
                end
            end

            assign in_ready = in_ready_q;
        end else begin : g_noskid
            always_comb begin
                m_valid_d = m_valid_q;
                m_ent_d   = m_ent_q;
                if (flush) begin
                    m_valid_d = 1'b0;
                    m_ent_d   = '0;
                end else if (accept) begin
                    m_valid_d = 1'b1;
                    m_ent_d   = in_ent;
                end else if (drain) begin
                    m_valid_d = 1'b0;
                    m_ent_d   = '0;
                end
            end

            assign in_ready = ~m_valid_q | out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_valid_q <= 1'b0;
            m_ent_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ent_q   <= m_ent_d;
        end
    end

    // Performance counter survives flushes; only reset clears it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_q <= '0;
        end else if (m_valid_q && !out_ready && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign out_valid = m_valid_q;
    assign {out_data, out_ex, out_excode, out_badvaddr} = m_ent_q;
    assign stall_cnt = stall_q;
endmodule
